// File: rtl/board_pkg.sv
// Shared types and constants for the battleship board controller.
package board_pkg;
  localparam int BOARD_CELLS = 256;
  localparam int CNT_WIDTH   = 9;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SHIP  = 2'd1,
    CELL_MISS  = 2'd2,
    CELL_HIT   = 2'd3
  } cell_t;

  typedef enum logic {
    OP_SHOT  = 1'b0,
    OP_PLACE = 1'b1
  } op_t;

  typedef enum logic [2:0] {
    RES_MISS   = 3'd0,
    RES_HIT    = 3'd1,
    RES_REPEAT = 3'd2,
    RES_OK     = 3'd3,
    RES_REJECT = 3'd4
  } result_t;

  // Counters stop at BOARD_CELLS instead of wrapping back to zero.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_WIDTH'(BOARD_CELLS)) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/board_ctl.sv
// Board controller: clears the board memory, then serves SHOT/PLACE requests
// with a read-evaluate-write sequence against an external 1-cycle-latency RAM.
module board_ctl
  import board_pkg::*;
#(
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int DATA_WIDTH   = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear_start,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_op,
  input  logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] req_addr,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic [2:0]                           resp_result,
  output logic                                 busy,
  output logic [CNT_WIDTH-1:0]                 ship_cnt,
  output logic [CNT_WIDTH-1:0]                 hit_cnt,
  output logic                                 all_sunk,
  output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] mem_waddr,
  output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  output logic                                 mem_we,
  input  logic [DATA_WIDTH-1:0]                mem_rdata
);
  localparam int AW = X_ADDR_WIDTH + Y_ADDR_WIDTH;

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]           r_state;
  logic [AW-1:0]        r_clr_addr;
  logic [AW-1:0]        r_addr;
  op_t                  r_op;
  result_t              r_result;
  logic [CNT_WIDTH-1:0] r_ship_cnt;
  logic [CNT_WIDTH-1:0] r_hit_cnt;

  cell_t   w_cell;
  cell_t   w_wcell;
  result_t w_res;
  logic    w_wr;
  logic    w_ship_inc;
  logic    w_hit_inc;

  assign w_cell = cell_t'(mem_rdata[1:0]);

  always_comb begin
    w_wr       = 1'b0;
    w_wcell    = CELL_EMPTY;
    w_res      = RES_MISS;
    w_ship_inc = 1'b0;
    w_hit_inc  = 1'b0;
    if (r_op == OP_SHOT) begin
      case (w_cell)
        CELL_EMPTY: begin w_wr = 1'b1; w_wcell = CELL_MISS; w_res = RES_MISS; end
        CELL_SHIP:  begin w_wr = 1'b1; w_wcell = CELL_HIT;  w_res = RES_HIT; w_hit_inc = 1'b1; end
        default:    w_res = RES_REPEAT;
      endcase
    end else begin
      if (w_cell == CELL_EMPTY) begin
        w_wr = 1'b1; w_wcell = CELL_SHIP; w_res = RES_OK; w_ship_inc = 1'b1;
      end else begin
        w_res = RES_REJECT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_addr     <= '0;
      r_op       <= OP_SHOT;
      r_result   <= RES_MISS;
      r_ship_cnt <= '0;
      r_hit_cnt  <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (r_clr_addr == {AW{1'b1}}) begin
            r_ship_cnt <= '0;
            r_hit_cnt  <= '0;
            r_state    <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (clear_start) begin
            r_clr_addr <= '0;
            r_state    <= S_CLEAR;
          end else if (req_valid) begin
            r_op    <= op_t'(req_op);
            r_addr  <= req_addr;
            r_state <= S_READ;
          end
        end
        S_READ: r_state <= S_EVAL;
        S_EVAL: begin
          r_result <= w_res;
          if (w_ship_inc) r_ship_cnt <= sat_inc(r_ship_cnt);
          if (w_hit_inc)  r_hit_cnt  <= sat_inc(r_hit_cnt);
          r_state <= S_RESP;
        end
        S_RESP: if (resp_ready) r_state <= S_IDLE;
        default: begin
          r_clr_addr <= '0;
          r_state    <= S_CLEAR;
        end
      endcase
    end
  end

  assign req_ready   = (r_state == S_IDLE) && !clear_start;
  assign resp_valid  = (r_state == S_RESP);
  assign resp_result = r_result;
  assign busy        = (r_state != S_IDLE);
  assign ship_cnt    = r_ship_cnt;
  assign hit_cnt     = r_hit_cnt;
  assign all_sunk    = (r_ship_cnt != '0) && (r_hit_cnt == r_ship_cnt);

  // Write enable is gated by rst_n so a reset landing in EVAL or CLEAR
  // cannot leave a write strobe on the bus while reset is held.
  assign mem_we    = rst_n && ((r_state == S_CLEAR) || ((r_state == S_EVAL) && w_wr));
  assign mem_waddr = (r_state == S_CLEAR) ? r_clr_addr : r_addr;
  assign mem_wdata = (r_state == S_CLEAR) ? '0 : DATA_WIDTH'(w_wcell);
  assign mem_raddr = r_addr;
endmodule

// File: tb/tb_board_ctl.sv
// Self-checking bench for board_ctl with a behavioural board model and RAM.
module tb_board_ctl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_start = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_op = 1'b0;
  logic [7:0] req_addr = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [2:0] resp_result;
  logic       busy;
  logic [8:0] ship_cnt, hit_cnt;
  logic       all_sunk;
  logic [7:0] mem_waddr, mem_raddr;
  logic [1:0] mem_wdata;
  logic       mem_we;
  logic [1:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;

  logic [1:0] tb_mem [256];
  int wr_count = 0;

  // Reference board: 0 empty, 1 ship, 2 miss, 3 hit
  int ref_board [256];
  int ref_ship = 0;
  int ref_hit = 0;

  board_ctl dut (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .busy(busy), .ship_cnt(ship_cnt), .hit_cnt(hit_cnt), .all_sunk(all_sunk),
    .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_waddr] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
    mem_rdata <= tb_mem[mem_raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < 256; i++) ref_board[i] = 0;
    ref_ship = 0;
    ref_hit = 0;
  endtask

  // Applies the game rules to the model; returns result code and write count.
  task automatic ref_apply(input bit op, input int a, output int res, output int nwr);
    nwr = 0;
    if (op == 1'b0) begin
      if (ref_board[a] == 0)      begin ref_board[a] = 2; res = 0; nwr = 1; end
      else if (ref_board[a] == 1) begin ref_board[a] = 3; res = 1; nwr = 1; ref_hit++; end
      else res = 2;
    end else begin
      if (ref_board[a] == 0) begin ref_board[a] = 1; res = 3; nwr = 1; ref_ship++; end
      else res = 4;
    end
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (req_ready !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check(tag, req_ready, 1'b1);
  endtask

  task automatic do_txn(input bit op, input logic [7:0] addr, input int hold, input bit clr_in_read);
    int n, exp_res, exp_wr, wc0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr;
    wait_ready("req_ready_wait", n);
    @(negedge clk);
    req_valid = 1'b0;
    check("read_resp_valid", resp_valid, 1'b0);
    check("read_raddr", mem_raddr, addr);
    if (clr_in_read) clear_start = 1'b1;
    ref_apply(op, int'(addr), exp_res, exp_wr);
    wc0 = wr_count;
    @(negedge clk);
    clear_start = 1'b0;
    check("eval_resp_valid", resp_valid, 1'b0);
    @(negedge clk);
    check("resp_valid", resp_valid, 1'b1);
    check("resp_result", resp_result, exp_res[2:0]);
    check("write_count", wr_count - wc0, exp_wr);
    check("ship_cnt", ship_cnt, ref_ship[8:0]);
    check("hit_cnt", hit_cnt, ref_hit[8:0]);
    check("all_sunk", all_sunk, (ref_ship != 0) && (ref_hit == ref_ship));
    check("cell_value", tb_mem[addr], ref_board[addr][1:0]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", resp_valid, 1'b1);
      check("hold_result", resp_result, exp_res[2:0]);
      check("hold_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_resp_valid", resp_valid, 1'b0);
    check("post_busy", busy, 1'b0);
  endtask

  initial begin
    int n, bad;
    for (int i = 0; i < 256; i++) tb_mem[i] = 2'($urandom_range(0, 3));
    ref_clear();

    // Reset state
    #12;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_counts", {ship_cnt, hit_cnt}, 18'd0);
    check("rst_result", resp_result, 3'd0);

    // Clear sweep after reset release
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      #1;
      if (!(mem_we === 1'b1 && mem_waddr === 8'(i) && mem_wdata === 2'd0 &&
            busy === 1'b1 && req_ready === 1'b0)) bad++;
      @(negedge clk);
    end
    check("clear_sweep_bad_cycles", bad, 0);
    check("ready_on_cycle_257", req_ready, 1'b1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== 2'd0) bad++;
    check("board_cleared", bad, 0);

    // Directed transactions
    do_txn(1'b1, 8'h35, 0, 1'b0);   // PLACE -> OK
    do_txn(1'b0, 8'h35, 0, 1'b0);   // SHOT  -> HIT, all_sunk
    do_txn(1'b0, 8'h00, 0, 1'b0);   // MISS
    do_txn(1'b0, 8'h00, 0, 1'b0);   // REPEAT
    do_txn(1'b1, 8'h7F, 0, 1'b0);   // OK
    do_txn(1'b1, 8'h7F, 5, 1'b0);   // REJECT with resp_ready held low
    do_txn(1'b1, 8'h22, 0, 1'b1);   // clear_start in READ is ignored
    check("no_clear_after_read_pulse", tb_mem[8'h35], 2'd3);

    // Randomized traffic against the model
    for (int k = 0; k < 40; k++)
      do_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 23)), $urandom_range(0, 2), 1'b0);

    // clear_start wins over a pending request in IDLE
    @(negedge clk);
    clear_start = 1'b1; req_valid = 1'b1; req_op = 1'b1; req_addr = 8'h44;
    #1;
    check("clr_vs_req_ready", req_ready, 1'b0);
    @(negedge clk);
    clear_start = 1'b0;
    check("clr_started_we", mem_we, 1'b1);
    check("clr_started_addr", mem_waddr, 8'h00);
    ref_clear();
    do_txn(1'b1, 8'h44, 0, 1'b0);
    check("ship_after_clear", ship_cnt, 9'd1);

    // Reset pulse mid-clear restarts at address 0
    @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    n = 0;
    while (mem_waddr !== 8'h80 && n < 300) begin @(negedge clk); n++; end
    check("reach_clear_0x80", mem_waddr, 8'h80);
    rst_n = 1'b0;
    #1;
    check("midclear_rst_we", mem_we, 1'b0);
    check("midclear_rst_busy", busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("restart_addr", mem_waddr, 8'h00);
    check("restart_we", mem_we, 1'b1);
    wait_ready("restart_ready", n);
    check("restart_cycles", n, 256);
    ref_clear();

    // Reset during EVAL aborts the pending write
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b1; req_addr = 8'h10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("eval_we_pending", mem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_we", mem_we, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_no_write", tb_mem[8'h10], 2'd0);
    check("abort_resp_valid", resp_valid, 1'b0);
    wait_ready("abort_ready", n);
    check("abort_ship_cnt", ship_cnt, 9'd0);
    do_txn(1'b0, 8'h10, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
